// File: rtl/slave_in_port.sv
// Serial slave input port: deserialises address, burst length and write data
// from the master out port. Define SLAVE_PARITY_EN to enable even-parity checks.
module slave_in_port #(
    parameter int WORD_SIZE       = 8,
    parameter int SLAVE_ADDR_SIZE = 12,
    parameter int BURST_SIZE      = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       slave_sel,
    input  logic                       read_en,
    input  logic                       write_en,
    input  logic                       m_valid,
    input  logic                       addr_bus,
    input  logic                       burst_size_bus,
    input  logic                       w_data_bus,
    output logic                       s_ready,
    output logic [SLAVE_ADDR_SIZE-1:0] s_addr,
    output logic [BURST_SIZE-1:0]      s_burst,
    output logic [WORD_SIZE-1:0]       s_wdata,
    output logic                       s_wvalid,
    output logic                       s_rreq,
    input  logic                       s_rdone,
    output logic                       s_err,
    output logic                       s_busy
);

`ifdef SLAVE_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int MAX_BITS = (SLAVE_ADDR_SIZE > WORD_SIZE) ? SLAVE_ADDR_SIZE : WORD_SIZE;
    localparam int CNT_W    = $clog2(MAX_BITS + 2);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(SLAVE_ADDR_SIZE - 1 + PAR_BITS);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_SIZE - 1 + PAR_BITS);

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, RREQ, RWAIT} state_t;

    state_t                     state;
    state_t                     next_state;
    logic                       is_write;
    logic [CNT_W-1:0]           bit_cnt;
    logic [SLAVE_ADDR_SIZE-1:0] base;
    logic [WORD_SIZE-1:0]       word_sh;
    logic [BURST_SIZE-1:0]      word_idx;

    logic                       start;
    logic                       sample;
    logic                       abort;
    logic                       addr_end;
    logic                       word_end;
    logic                       last_word;
    logic                       wdata_done;
    logic                       addr_shift;
    logic                       word_shift;
    logic                       addr_par_ok;
    logic                       word_par_ok;
    logic [WORD_SIZE-1:0]       word_full;
    logic [BURST_SIZE-1:0]      burst_eff;

    always_comb begin
        start      = (state == IDLE) && slave_sel && (read_en ^ write_en);
        sample     = slave_sel && m_valid;
        burst_eff  = (s_burst == '0) ? BURST_SIZE'(1) : s_burst;
        last_word  = (word_idx == (burst_eff - BURST_SIZE'(1)));
        // The last word's pulse cycle still sits in WDATA; it must not be aborted or sampled.
        wdata_done = (state == WDATA) && s_wvalid && last_word;
        abort      = !slave_sel && ((state == ADDR) || ((state == WDATA) && !wdata_done));
        addr_end   = (state == ADDR) && sample && (bit_cnt == ADDR_LAST);
        word_end   = (state == WDATA) && !wdata_done && sample && (bit_cnt == WORD_LAST);
`ifdef SLAVE_PARITY_EN
        addr_shift  = (bit_cnt != ADDR_LAST);
        word_shift  = (bit_cnt != WORD_LAST);
        word_full   = word_sh;
        addr_par_ok = ~(^base ^ addr_bus);
        word_par_ok = ~(^word_sh ^ w_data_bus);
`else
        addr_shift  = 1'b1;
        word_shift  = 1'b1;
        word_full   = {w_data_bus, word_sh[WORD_SIZE-1:1]};
        addr_par_ok = 1'b1;
        word_par_ok = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = ADDR;
            ADDR: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (addr_end) begin
                    if (!addr_par_ok) next_state = IDLE;
                    else              next_state = is_write ? WDATA : RREQ;
                end
            end
            WDATA: begin
                if (wdata_done || abort)          next_state = IDLE;
                else if (word_end && !word_par_ok) next_state = IDLE;
            end
            RREQ:  next_state = RWAIT;
            RWAIT: if (s_rdone) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        s_busy  = (state != IDLE);
        s_ready = (state == IDLE);
        s_rreq  = (state == RREQ);
        s_addr  = base + SLAVE_ADDR_SIZE'(word_idx);
    end

    // Serial bits arrive LSB first, so each register shifts right from the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_write <= 1'b0;
            bit_cnt  <= '0;
            base     <= '0;
            word_sh  <= '0;
            word_idx <= '0;
            s_burst  <= '0;
            s_wdata  <= '0;
            s_wvalid <= 1'b0;
            s_err    <= 1'b0;
        end else begin
            s_wvalid <= 1'b0;
            s_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_write <= write_en;
                        bit_cnt  <= '0;
                        word_idx <= '0;
                    end
                end
                ADDR: begin
                    if (abort) begin
                        s_err   <= 1'b1;
                        bit_cnt <= '0;
                    end else if (sample) begin
                        if (addr_shift) begin
                            base    <= {addr_bus, base[SLAVE_ADDR_SIZE-1:1]};
                            s_burst <= {burst_size_bus, s_burst[BURST_SIZE-1:1]};
                        end
                        if (addr_end) begin
                            bit_cnt <= '0;
                            s_err   <= !addr_par_ok;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                WDATA: begin
                    if (abort) begin
                        s_err   <= 1'b1;
                        bit_cnt <= '0;
                    end else if (!wdata_done) begin
                        if (s_wvalid) word_idx <= word_idx + BURST_SIZE'(1);
                        if (sample) begin
                            if (word_shift) word_sh <= {w_data_bus, word_sh[WORD_SIZE-1:1]};
                            if (word_end) begin
                                bit_cnt <= '0;
                                if (word_par_ok) begin
                                    s_wvalid <= 1'b1;
                                    s_wdata  <= word_full;
                                end else begin
                                    s_err <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
